stream_max_finder: RTL and testbench

STREAM_MAX_FINDER -- requirements
Module: stream_max_finder

---
 rtl/stream_max_finder.sv | 100 ++++++++++
 tb/tb_stream_max_finder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_max_finder.sv
// Frame-based extreme finder: scans COUNT samples per frame and reports the
// largest (or smallest) value and its first position, with valid/ready on both sides.
module stream_max_finder #(
  parameter  int WIDTH  = 8,
  parameter  int COUNT  = 3,
  parameter  int SIGNED = 0,
  localparam int IDXW   = (COUNT > 1) ? $clog2(COUNT) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode_min,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_value,
  output logic [IDXW-1:0]  out_index
);

  typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_t;

  state_t            state;
  state_t            state_next;
  logic [IDXW-1:0]   cnt;
  logic [WIDTH-1:0]  best;
  logic [IDXW-1:0]   best_idx;
  logic              mode_q;
  logic [WIDTH-1:0]  res_value;
  logic [IDXW-1:0]   res_idx;

  logic              accept;
  logic              last;
  logic              better;
  logic              take;
  logic [WIDTH-1:0]  cand_value;
  logic [IDXW-1:0]   cand_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (accept && last) state_next = DONE;
      DONE:    if (out_ready)      state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == DONE);
  end

  assign accept = in_valid && in_ready;
  assign last   = (cnt == IDXW'(COUNT - 1));

  // Strict comparison so ties keep the earlier index; the first sample always loads.
  always_comb begin
    better = 1'b0;
    if (SIGNED != 0)
      better = mode_q ? ($signed(in_data) < $signed(best)) : ($signed(in_data) > $signed(best));
    else
      better = mode_q ? (in_data < best) : (in_data > best);
    take       = (cnt == '0) || better;
    cand_value = take ? in_data : best;
    cand_idx   = take ? cnt : best_idx;
  end

  // The result registers are separate from the running best so the delivered
  // result stays visible while the next frame accumulates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      best      <= '0;
      best_idx  <= '0;
      mode_q    <= 1'b0;
      res_value <= '0;
      res_idx   <= '0;
    end else if (accept) begin
      best     <= cand_value;
      best_idx <= cand_idx;
      if (cnt == '0) mode_q <= mode_min;
      if (last) begin
        cnt       <= '0;
        res_value <= cand_value;
        res_idx   <= cand_idx;
      end else begin
        cnt <= cnt + IDXW'(1);
      end
    end
  end

  assign out_value = res_value;
  assign out_index = res_idx;

endmodule

// File: tb/tb_stream_max_finder.sv
// Self-checking bench: three instances (unsigned COUNT=3, signed COUNT=3, COUNT=1)
// driven by directed and random frames, checked against a whole-frame search model.
module tb_stream_max_finder;

  logic       clk = 1'b0;
  logic       rst_n     [3];
  logic       mode_min  [3];
  logic       in_valid  [3];
  logic       in_ready  [3];
  logic [7:0] in_data   [3];
  logic       out_valid [3];
  logic       out_ready [3];
  logic [7:0] out_value [3];
  logic [1:0] idx0;
  logic [1:0] idx1;
  logic       idx2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stream_max_finder #(.WIDTH(8), .COUNT(3), .SIGNED(0)) dut_u (
    .clk(clk), .rst_n(rst_n[0]), .mode_min(mode_min[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .in_data(in_data[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_value(out_value[0]), .out_index(idx0)
  );

  stream_max_finder #(.WIDTH(8), .COUNT(3), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n[1]), .mode_min(mode_min[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .in_data(in_data[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_value(out_value[1]), .out_index(idx1)
  );

  stream_max_finder #(.WIDTH(8), .COUNT(1), .SIGNED(0)) dut_1 (
    .clk(clk), .rst_n(rst_n[2]), .mode_min(mode_min[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .in_data(in_data[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_value(out_value[2]), .out_index(idx2)
  );

  function automatic int countOf(input int d);
    return (d == 2) ? 1 : 3;
  endfunction

  function automatic int idxOf(input int d);
    case (d)
      0:       return int'(idx0);
      1:       return int'(idx1);
      default: return int'(idx2);
    endcase
  endfunction

  // Reference: linear search over the whole frame, values interpreted as integers.
  function automatic void refModel(input logic [7:0] s[$], input bit mode, input bit sgn,
                                   output logic [7:0] v, output int idx);
    int best;
    int cur;
    idx  = 0;
    best = sgn ? int'($signed(s[0])) : int'(s[0]);
    for (int i = 1; i < s.size(); i++) begin
      cur = sgn ? int'($signed(s[i])) : int'(s[i]);
      if (mode ? (cur < best) : (cur > best)) begin
        best = cur;
        idx  = i;
      end
    end
    v = s[idx];
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input int d, input logic [7:0] ev, input int ei, input string tag);
    checkOutput($sformatf("d%0d %s out_valid", d, tag), 32'(out_valid[d]), 0);
    checkOutput($sformatf("d%0d %s in_ready", d, tag), 32'(in_ready[d]), 1);
    checkOutput($sformatf("d%0d %s out_value", d, tag), 32'(out_value[d]), 32'(ev));
    checkOutput($sformatf("d%0d %s out_index", d, tag), idxOf(d), ei);
  endtask

  task automatic checkDone(input int d, input logic [7:0] ev, input int ei, input string tag);
    checkOutput($sformatf("d%0d %s out_valid", d, tag), 32'(out_valid[d]), 1);
    checkOutput($sformatf("d%0d %s in_ready", d, tag), 32'(in_ready[d]), 0);
    checkOutput($sformatf("d%0d %s out_value", d, tag), 32'(out_value[d]), 32'(ev));
    checkOutput($sformatf("d%0d %s out_index", d, tag), idxOf(d), ei);
  endtask

  // Send one frame, optionally with idle gaps and mid-frame mode noise, then hold
  // the result for bp cycles before the handshake; junk in_valid during DONE and
  // the handshake cycle must be ignored.
  task automatic applyStimulus(input int d, input bit mode, input logic [7:0] s[$],
                               input int bp, input bit gaps);
    logic [7:0] ev;
    int         ei;
    refModel(s, mode, d == 1, ev, ei);
    out_ready[d] = 1'b0;
    for (int i = 0; i < s.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid[d] = 1'b0;
          in_data[d]  = 8'($urandom_range(0, 255));
          mode_min[d] = 1'($urandom_range(0, 1));
          step();
        end
      end
      checkOutput($sformatf("d%0d sample%0d in_ready", d, i), 32'(in_ready[d]), 1);
      in_valid[d] = 1'b1;
      in_data[d]  = s[i];
      mode_min[d] = (i == 0) ? mode : 1'($urandom_range(0, 1));
      step();
    end
    in_valid[d] = 1'b0;
    in_data[d]  = 8'($urandom_range(0, 255));
    mode_min[d] = 1'($urandom_range(0, 1));
    checkDone(d, ev, ei, "result");
    for (int k = 0; k < bp; k++) begin
      in_valid[d] = 1'($urandom_range(0, 1));
      in_data[d]  = 8'($urandom_range(0, 255));
      step();
      checkDone(d, ev, ei, $sformatf("hold%0d", k));
    end
    out_ready[d] = 1'b1;
    in_valid[d]  = 1'b1;
    in_data[d]   = 8'($urandom_range(0, 255));
    step();
    out_ready[d] = 1'b0;
    in_valid[d]  = 1'b0;
    checkIdle(d, ev, ei, "after_handshake");
  endtask

  task automatic frame3(input int d, input bit mode, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input int bp);
    logic [7:0] q[$];
    q.push_back(a);
    q.push_back(b);
    q.push_back(c);
    applyStimulus(d, mode, q, bp, 1'b0);
  endtask

  task automatic frame1(input bit mode, input logic [7:0] a);
    logic [7:0] q[$];
    q.push_back(a);
    applyStimulus(2, mode, q, 0, 1'b0);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] q[$];
    int         d;
    for (int i = 0; i < 3; i++) begin
      rst_n[i]     = 1'b0;
      mode_min[i]  = 1'b0;
      in_valid[i]  = 1'b0;
      in_data[i]   = 8'h00;
      out_ready[i] = 1'b0;
    end
    repeat (2) step();
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    for (int i = 0; i < 3; i++) checkIdle(i, 8'h00, 0, "reset");

    $display("[TB] unsigned max and ties");
    frame3(0, 1'b0, 8'd10, 8'd25, 8'd15, 0);
    frame3(0, 1'b0, 8'd5, 8'd5, 8'd5, 0);
    frame3(0, 1'b0, 8'd7, 8'd7, 8'd9, 0);

    $display("[TB] signedness");
    frame3(1, 1'b1, 8'hFD, 8'h02, 8'h80, 0);
    frame3(0, 1'b0, 8'hFD, 8'h02, 8'h80, 0);

    $display("[TB] backpressure");
    frame3(0, 1'b0, 8'd50, 8'd20, 8'd30, 5);

    $display("[TB] reset mid-frame");
    in_valid[0] = 1'b1;
    in_data[0]  = 8'd40;
    step();
    in_data[0]  = 8'd90;
    step();
    in_valid[0] = 1'b0;
    rst_n[0]    = 1'b0;
    step();
    rst_n[0]    = 1'b1;
    checkIdle(0, 8'h00, 0, "midframe_reset");
    frame3(0, 1'b0, 8'd1, 8'd2, 8'd3, 0);

    $display("[TB] reset against handshake in DONE");
    in_valid[0] = 1'b1;
    mode_min[0] = 1'b0;
    in_data[0]  = 8'd100;
    step();
    in_data[0]  = 8'd200;
    step();
    in_data[0]  = 8'd50;
    step();
    in_valid[0] = 1'b0;
    checkDone(0, 8'd200, 1, "pre_reset");
    rst_n[0]     = 1'b0;
    out_ready[0] = 1'b1;
    step();
    rst_n[0]     = 1'b1;
    out_ready[0] = 1'b0;
    checkIdle(0, 8'h00, 0, "done_reset");

    $display("[TB] COUNT=1 with mode toggling");
    frame1(1'b0, 8'd8);
    frame1(1'b1, 8'd3);

    $display("[TB] random frames");
    for (int k = 0; k < 30; k++) begin
      d = int'($urandom_range(0, 2));
      q.delete();
      for (int i = 0; i < countOf(d); i++) q.push_back(8'($urandom_range(0, 255)));
      applyStimulus(d, 1'($urandom_range(0, 1)), q, int'($urandom_range(0, 3)), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
